// File: rtl/hvgen_pkg.sv
// Shared timing presets and helpers for the parametrised H/V video timing generator.
package hvgen_pkg;

    // Legal range of the internal pixel-enable divider
    localparam int unsigned CE_DIV_MIN = 2;
    localparam int unsigned CE_DIV_MAX = 256;

    // 240x224 mode (timing of the original fixed generator)
    localparam int unsigned T240_H_TOTAL       = 384;
    localparam int unsigned T240_H_BLANK_END   = 10;
    localparam int unsigned T240_H_BLANK_START = 250;
    localparam int unsigned T240_H_SYNC_START  = 308;
    localparam int unsigned T240_H_SYNC_END    = 340;
    localparam int unsigned T240_V_TOTAL       = 264;
    localparam int unsigned T240_V_BLANK_END   = 16;
    localparam int unsigned T240_V_BLANK_START = 240;
    localparam int unsigned T240_V_SYNC_START  = 258;
    localparam int unsigned T240_V_SYNC_END    = 260;

    // 256x224 mode (same line/frame totals, wider active window)
    localparam int unsigned T256_H_TOTAL       = 384;
    localparam int unsigned T256_H_BLANK_END   = 10;
    localparam int unsigned T256_H_BLANK_START = 266;
    localparam int unsigned T256_H_SYNC_START  = 300;
    localparam int unsigned T256_H_SYNC_END    = 332;
    localparam int unsigned T256_V_TOTAL       = 264;
    localparam int unsigned T256_V_BLANK_END   = 16;
    localparam int unsigned T256_V_BLANK_START = 240;
    localparam int unsigned T256_V_SYNC_START  = 258;
    localparam int unsigned T256_V_SYNC_END    = 260;

    // Pin level for a sync signal given whether sync is currently active
    function automatic logic sync_level(input logic active, input logic sync_neg);
        return sync_neg ? ~active : active;
    endfunction

endpackage

// File: rtl/hvgen_cen.sv
// Pixel-enable source: internal clk_sys divider or pass-through of an external enable.
module hvgen_cen
    import hvgen_pkg::*;
#(
    parameter int unsigned CE_EXT = 0,
    parameter int unsigned CE_DIV = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce_in,
    output logic tick_c
);

    generate
        if (CE_EXT != 0) begin : g_ext
            logic unused_clk;
            assign unused_clk = clk_sys ^ reset_n;

            // External enable is the tick directly
            assign tick_c = ce_in;
        end else begin : g_int
            localparam int unsigned DW = $clog2(CE_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

            logic [DW-1:0] div;
            logic          unused_ce;
            assign unused_ce = ce_in;

            assign tick_c = (div == DIV_LAST);

            // Divider counts 0..CE_DIV-1 and wraps on the tick
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    div <= '0;
                end else if (tick_c) begin
                    div <= '0;
                end else begin
                    div <= div + DW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/hvgen_param.sv
// Parametrised video timing generator: H/V counters, blank/sync flags, pixel enable and strobes.
// Optional feature macro: HVGEN_SYNC_ADJUST_EN adds per-frame signed sync position offsets.
module hvgen_param
    import hvgen_pkg::*;
#(
    parameter int unsigned HW            = 9,
    parameter int unsigned VW            = 9,
    parameter int unsigned CE_EXT        = 0,
    parameter int unsigned CE_DIV        = 8,
    parameter int unsigned H_TOTAL       = T240_H_TOTAL,
    parameter int unsigned H_BLANK_END   = T240_H_BLANK_END,
    parameter int unsigned H_BLANK_START = T240_H_BLANK_START,
    parameter int unsigned H_SYNC_START  = T240_H_SYNC_START,
    parameter int unsigned H_SYNC_END    = T240_H_SYNC_END,
    parameter int unsigned V_TOTAL       = T240_V_TOTAL,
    parameter int unsigned V_BLANK_END   = T240_V_BLANK_END,
    parameter int unsigned V_BLANK_START = T240_V_BLANK_START,
    parameter int unsigned V_SYNC_START  = T240_V_SYNC_START,
    parameter int unsigned V_SYNC_END    = T240_V_SYNC_END,
    parameter bit          SYNC_NEG      = 1'b1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ce_in,
`ifdef HVGEN_SYNC_ADJUST_EN
    input  logic signed [3:0]    h_adj,
    input  logic signed [2:0]    v_adj,
`endif
    output logic [HW-1:0]        hcount,
    output logic [VW-1:0]        vcount,
    output logic                 hb,
    output logic                 vb,
    output logic                 hs,
    output logic                 vs,
    output logic                 ce_pix,
    output logic                 line_start,
    output logic                 frame_start
);

    // Reject inconsistent timing at elaboration
    if (!(H_BLANK_END < H_BLANK_START && H_BLANK_START < H_SYNC_START &&
          H_SYNC_START < H_SYNC_END && H_SYNC_END < H_TOTAL &&
          64'(H_TOTAL) <= (64'd1 << HW))) begin : g_bad_h
        $error("hvgen_param: horizontal timing points out of order or exceed HW");
    end
    if (!(V_BLANK_END < V_BLANK_START && V_BLANK_START < V_SYNC_START &&
          V_SYNC_START < V_SYNC_END && V_SYNC_END < V_TOTAL &&
          64'(V_TOTAL) <= (64'd1 << VW))) begin : g_bad_v
        $error("hvgen_param: vertical timing points out of order or exceed VW");
    end
    if (CE_DIV < CE_DIV_MIN || CE_DIV > CE_DIV_MAX) begin : g_bad_div
        $error("hvgen_param: CE_DIV outside 2..256");
    end

    logic          tick_c;
    logic          eol_c;
    logic          eof_c;
    logic [HW-1:0] hss_c;
    logic [HW-1:0] hse_c;
    logic [VW-1:0] vss_c;
    logic [VW-1:0] vse_c;

    hvgen_cen #(
        .CE_EXT (CE_EXT),
        .CE_DIV (CE_DIV)
    ) u_cen (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce_in   (ce_in),
        .tick_c  (tick_c)
    );

    assign eol_c = (hcount == HW'(H_TOTAL - 1));
    assign eof_c = eol_c && (vcount == VW'(V_TOTAL - 1));

`ifdef HVGEN_SYNC_ADJUST_EN
    // Offsets span -8..+7 / -4..+3; every shifted sync point must stay in the blanking tail
    if (!(H_SYNC_START > H_BLANK_START + 8 && H_SYNC_END + 7 < H_TOTAL)) begin : g_bad_hadj
        $error("hvgen_param: adjusted horizontal sync range leaves blanking tail");
    end
    if (!(V_SYNC_START > V_BLANK_START + 4 && V_SYNC_END + 3 < V_TOTAL)) begin : g_bad_vadj
        $error("hvgen_param: adjusted vertical sync range leaves blanking tail");
    end

    logic signed [3:0] h_adj_q;
    logic signed [2:0] v_adj_q;

    // Offsets are captured only at frame start so a frame never mixes two sync positions
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            h_adj_q <= '0;
            v_adj_q <= '0;
        end else if (tick_c && eof_c) begin
            h_adj_q <= h_adj;
            v_adj_q <= v_adj;
        end
    end

    assign hss_c = HW'(H_SYNC_START) + HW'(h_adj_q);
    assign hse_c = HW'(H_SYNC_END)   + HW'(h_adj_q);
    assign vss_c = VW'(V_SYNC_START) + VW'(v_adj_q);
    assign vse_c = VW'(V_SYNC_END)   + VW'(v_adj_q);
`else
    assign hss_c = HW'(H_SYNC_START);
    assign hse_c = HW'(H_SYNC_END);
    assign vss_c = VW'(V_SYNC_START);
    assign vse_c = VW'(V_SYNC_END);
`endif

    // Strobes mark the clk in which the freshly updated counters appear
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ce_pix      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            ce_pix      <= tick_c;
            line_start  <= tick_c && eol_c;
            frame_start <= tick_c && eof_c;
        end
    end

    // Horizontal counter and flags; compares use the pre-update hcount (one-pixel lag)
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            hb     <= 1'b1;
            hs     <= sync_level(1'b0, SYNC_NEG);
        end else if (tick_c) begin
            hcount <= eol_c ? '0 : hcount + HW'(1);
            if (hcount == HW'(H_BLANK_END)) begin
                hb <= 1'b0;
            end else if (hcount == HW'(H_BLANK_START)) begin
                hb <= 1'b1;
            end
            if (hcount == hss_c) begin
                hs <= sync_level(1'b1, SYNC_NEG);
            end else if (hcount == hse_c) begin
                hs <= sync_level(1'b0, SYNC_NEG);
            end
        end
    end

    // Vertical counter and flags advance only on the end-of-line tick
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            vcount <= '0;
            vb     <= 1'b1;
            vs     <= sync_level(1'b0, SYNC_NEG);
        end else if (tick_c && eol_c) begin
            vcount <= eof_c ? '0 : vcount + VW'(1);
            if (vcount == VW'(V_BLANK_END)) begin
                vb <= 1'b0;
            end else if (vcount == VW'(V_BLANK_START)) begin
                vb <= 1'b1;
            end
            if (vcount == vss_c) begin
                vs <= sync_level(1'b1, SYNC_NEG);
            end else if (vcount == vse_c) begin
                vs <= sync_level(1'b0, SYNC_NEG);
            end
        end
    end

endmodule
